// File: rtl/e203_ifu_bjp_sched.sv
// Branch/jump prediction scheduler for the IFU: resolves JAL/BXX targets at accept,
// and for JALR waits out rs1 hazards, then reads x1 directly or via the shared regfile port.
module e203_ifu_bjp_sched #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               dec_valid_i,
    output logic               dec_ready_o,
    input  logic               dec_jal_i,
    input  logic               dec_jalr_i,
    input  logic               dec_bxx_i,
    input  logic [RFIDX_W-1:0] dec_jalr_rs1idx_i,
    input  logic [XLEN-1:0]    dec_bjp_imm_i,
    input  logic [XLEN-1:0]    dec_pc_i,
    input  logic               ir_rs1_dep_i,
    input  logic               oitf_empty_i,
    input  logic [XLEN-1:0]    x1_val_i,
    output logic               rf_rd_req_o,
    output logic [RFIDX_W-1:0] rf_rd_idx_o,
    input  logic               rf_rd_gnt_i,
    input  logic [XLEN-1:0]    rf_rd_data_i,
    output logic               prdt_valid_o,
    output logic               prdt_taken_o,
    output logic [XLEN-1:0]    prdt_pc_o,
    input  logic               prdt_ready_i,
    input  logic               flush_i
);

    typedef enum logic [1:0] {StIdle, StWaitDep, StRdReq, StResp} state_e;

    localparam logic [XLEN-1:0]    PcStep    = XLEN'(4);
    localparam logic [XLEN-1:0]    JalrMask  = ~XLEN'(1);
    localparam logic [RFIDX_W-1:0] IdxX1     = RFIDX_W'(1);

    state_e             state_q, state_d;
    logic               taken_q, taken_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [RFIDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic               accept;

    assign dec_ready_o  = (state_q == StIdle) & ~flush_i;
    assign accept       = dec_valid_i & dec_ready_o;
    assign rf_rd_req_o  = (state_q == StRdReq);
    assign rf_rd_idx_o  = idx_q;
    assign prdt_valid_o = (state_q == StResp);
    assign prdt_taken_o = taken_q;
    assign prdt_pc_o    = pc_q;

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        imm_d   = imm_q;
        // Flush wins over everything, including a coincident grant.
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept && dec_jal_i) begin
                        taken_d = 1'b1;
                        pc_d    = dec_pc_i + dec_bjp_imm_i;
                        state_d = StResp;
                    end else if (accept && dec_bxx_i) begin
                        taken_d = dec_bjp_imm_i[XLEN-1];
                        pc_d    = dec_bjp_imm_i[XLEN-1] ? dec_pc_i + dec_bjp_imm_i
                                                        : dec_pc_i + PcStep;
                        state_d = StResp;
                    end else if (accept && dec_jalr_i) begin
                        taken_d = 1'b1;
                        if (dec_jalr_rs1idx_i == '0) begin
                            pc_d    = dec_bjp_imm_i & JalrMask;
                            state_d = StResp;
                        end else begin
                            idx_d   = dec_jalr_rs1idx_i;
                            imm_d   = dec_bjp_imm_i;
                            state_d = StWaitDep;
                        end
                    end
                end
                StWaitDep: begin
                    if (!ir_rs1_dep_i && oitf_empty_i) begin
                        if (idx_q == IdxX1) begin
                            pc_d    = (x1_val_i + imm_q) & JalrMask;
                            state_d = StResp;
                        end else begin
                            state_d = StRdReq;
                        end
                    end
                end
                StRdReq: begin
                    if (rf_rd_gnt_i) begin
                        pc_d    = (rf_rd_data_i + imm_q) & JalrMask;
                        state_d = StResp;
                    end
                end
                StResp: begin
                    if (prdt_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            taken_q <= 1'b0;
            pc_q    <= '0;
            idx_q   <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            imm_q   <= imm_d;
        end
    end

endmodule
